// File: rtl/lift_car_if.sv
`timescale 1ns/1ps
// Dispatcher/cabin-side bundle for one lift car: assignment handshake, cabin buttons,
// door sensor, and the status the car reports back.
interface lift_car_if #(
    parameter int NUM_FLOORS = 11,
    parameter int FLOOR_W    = 4
);
    logic                  assign_valid;
    logic [FLOOR_W-1:0]    assign_floor;
    logic                  assign_ready;
    logic [NUM_FLOORS-1:0] cabin_req;
    logic                  door_obstruct;
    logic [FLOOR_W+1:0]    liftstate;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic                  served_valid;
    logic [FLOOR_W-1:0]    served_floor;
    logic                  assign_err;

    modport master (
        output assign_valid, assign_floor, cabin_req, door_obstruct,
        input  assign_ready, liftstate, door_open, pending,
               served_valid, served_floor, assign_err
    );

    modport slave (
        input  assign_valid, assign_floor, cabin_req, door_obstruct,
        output assign_ready, liftstate, door_open, pending,
               served_valid, served_floor, assign_err
    );
endinterface

// File: rtl/lift_car_controller.sv
`timescale 1ns/1ps
// Per-car SCAN sequencer: collects stops in a pending bitmap, times floor-to-floor
// travel and door dwell, and reports {dir, floor} back to the dispatcher.
module lift_car_controller #(
    parameter int NUM_FLOORS    = 11,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16,
    parameter int MAX_PENDING   = 3
) (
    input  logic      clk,
    input  logic      rst,
    lift_car_if.slave bus
);
    localparam int TCNT_W = $clog2(TRAVEL_CYCLES);
    localparam int DCNT_W = $clog2(DOOR_CYCLES);
    localparam int PCNT_W = $clog2(NUM_FLOORS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MOVE  = 2'd1;
    localparam logic [1:0] ST_DOOR  = 2'd2;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b11;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [TCNT_W-1:0]  TRAVEL_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DCNT_W-1:0]  DOOR_LAST   = DCNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);
    localparam logic [PCNT_W-1:0]  PEND_LIMIT  = PCNT_W'(MAX_PENDING);

    logic [1:0]            state_q, state_d;
    logic [1:0]            dir_q, dir_d;
    logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TCNT_W-1:0]     travel_cnt_q, travel_cnt_d;
    logic [DCNT_W-1:0]     dwell_cnt_q, dwell_cnt_d;
    logic                  door_open_q, door_open_d;
    logic                  served_valid_q, served_valid_d;
    logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
    logic                  assign_err_q, assign_err_d;

    logic [PCNT_W-1:0]     pend_cnt;
    logic                  assign_ready;
    logic                  xfer;
    logic                  floor_in_range;
    logic                  assign_ok;
    logic [NUM_FLOORS-1:0] req_bits;
    logic [NUM_FLOORS-1:0] pend_all;
    logic [NUM_FLOORS-1:0] above_q, below_q, above_all, below_all;
    logic                  up_found, dn_found, head_up;
    logic [FLOOR_W-1:0]    up_floor, dn_floor;
    logic [FLOOR_W-1:0]    step_floor;
    logic                  fwd_work, rev_work;
    logic                  open_door;
    logic [FLOOR_W-1:0]    open_floor;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            pend_cnt = pend_cnt + PCNT_W'(pending_q[i]);
        end
    end

    assign assign_ready   = (pend_cnt < PEND_LIMIT);
    assign xfer           = bus.assign_valid & assign_ready;
    assign floor_in_range = ({1'b0, bus.assign_floor} < FLOOR_LIMIT);
    assign assign_ok      = xfer & floor_in_range;
    assign pend_all       = pending_q | req_bits;

    // Per-floor request merge and above/below masks relative to the car.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
        assign req_bits[gi]  = bus.cabin_req[gi] | (assign_ok & (bus.assign_floor == FLOOR_W'(gi)));
        assign above_q[gi]   = pending_q[gi] & (FLOOR_W'(gi) > cur_floor_q);
        assign below_q[gi]   = pending_q[gi] & (FLOOR_W'(gi) < cur_floor_q);
        assign above_all[gi] = pend_all[gi]  & (FLOOR_W'(gi) > cur_floor_q);
        assign below_all[gi] = pend_all[gi]  & (FLOOR_W'(gi) < cur_floor_q);
    end

    // Nearest stop above vs. below when starting from rest; a tie heads up.
    always_comb begin
        up_found = 1'b0;
        up_floor = '0;
        dn_found = 1'b0;
        dn_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above_q[i]) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below_q[i]) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
        head_up = up_found & (~dn_found | ((up_floor - cur_floor_q) <= (cur_floor_q - dn_floor)));
    end

    always_comb begin
        step_floor = cur_floor_q;
        if (dir_q == DIR_UP && cur_floor_q != TOP_FLOOR) begin
            step_floor = cur_floor_q + 1'b1;
        end else if (dir_q == DIR_DOWN && cur_floor_q != '0) begin
            step_floor = cur_floor_q - 1'b1;
        end
    end

    always_comb begin
        fwd_work = 1'b0;
        rev_work = 1'b0;
        if (dir_q == DIR_UP) begin
            fwd_work = |above_all;
            rev_work = |below_all;
        end else if (dir_q == DIR_DOWN) begin
            fwd_work = |below_all;
            rev_work = |above_all;
        end
    end

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        cur_floor_d    = cur_floor_q;
        pending_d      = pend_all;
        travel_cnt_d   = travel_cnt_q;
        dwell_cnt_d    = dwell_cnt_q;
        door_open_d    = door_open_q;
        served_valid_d = 1'b0;
        served_floor_d = served_floor_q;
        assign_err_d   = xfer & ~floor_in_range;
        open_door      = 1'b0;
        open_floor     = cur_floor_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_bits[cur_floor_q] | pending_q[cur_floor_q]) begin
                    open_door = 1'b1;
                end else if (|pending_q) begin
                    dir_d        = head_up ? DIR_UP : DIR_DOWN;
                    travel_cnt_d = '0;
                    state_d      = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d = '0;
                    cur_floor_d  = step_floor;
                    if (pend_all[step_floor]) begin
                        open_door  = 1'b1;
                        open_floor = step_floor;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                end
            end
            ST_DOOR: begin
                // Requests for the open floor are absorbed and keep the door open.
                pending_d[cur_floor_q] = 1'b0;
                if (req_bits[cur_floor_q] | bus.door_obstruct) begin
                    dwell_cnt_d = '0;
                end else if (dwell_cnt_q == DOOR_LAST) begin
                    door_open_d  = 1'b0;
                    dwell_cnt_d  = '0;
                    travel_cnt_d = '0;
                    state_d      = ST_MOVE;
                    if (!fwd_work) begin
                        if (rev_work) begin
                            dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        end else begin
                            dir_d   = DIR_IDLE;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (open_door) begin
            state_d               = ST_DOOR;
            door_open_d           = 1'b1;
            dwell_cnt_d           = '0;
            pending_d[open_floor] = 1'b0;
            served_valid_d        = 1'b1;
            served_floor_d        = open_floor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dir_q          <= DIR_IDLE;
            cur_floor_q    <= '0;
            pending_q      <= '0;
            travel_cnt_q   <= '0;
            dwell_cnt_q    <= '0;
            door_open_q    <= 1'b0;
            served_valid_q <= 1'b0;
            served_floor_q <= '0;
            assign_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            cur_floor_q    <= cur_floor_d;
            pending_q      <= pending_d;
            travel_cnt_q   <= travel_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
            door_open_q    <= door_open_d;
            served_valid_q <= served_valid_d;
            served_floor_q <= served_floor_d;
            assign_err_q   <= assign_err_d;
        end
    end

    assign bus.assign_ready = assign_ready;
    assign bus.liftstate    = {dir_q, cur_floor_q};
    assign bus.door_open    = door_open_q;
    assign bus.pending      = pending_q;
    assign bus.served_valid = served_valid_q;
    assign bus.served_floor = served_floor_q;
    assign bus.assign_err   = assign_err_q;

endmodule

// File: tb/tb_lift_car_controller.sv
`timescale 1ns/1ps
// Bench for lift_car_controller: a countdown/distance-search model checked every cycle,
// plus directed scenarios with hand-computed timing and ordering.
module tb_lift_car_controller;
    localparam int NF   = 11;
    localparam int TRV  = 4;
    localparam int DR   = 6;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lift_car_if #(.NUM_FLOORS(NF), .FLOOR_W(4)) bus ();

    lift_car_controller #(
        .NUM_FLOORS(NF), .FLOOR_W(4), .TRAVEL_CYCLES(TRV),
        .DOOR_CYCLES(DR), .MAX_PENDING(MAXP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: floor/dir as integers, countdown of remaining cycles in the current segment or dwell.
    int            m_floor, m_dir, m_mode, m_left, m_sf;
    logic [NF-1:0] m_pend;
    logic          m_door, m_sv, m_err;

    task automatic model_reset();
        m_floor = 0; m_dir = 0; m_mode = 0; m_left = 0; m_sf = 0;
        m_pend = '0; m_door = 1'b0; m_sv = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_open();
        m_mode = 2; m_door = 1'b1; m_left = DR;
        m_pend[m_floor] = 1'b0; m_sv = 1'b1; m_sf = m_floor;
    endtask

    task automatic model_step(input logic av, input logic [3:0] af, input logic [NF-1:0] creq, input logic obs);
        logic [NF-1:0] newreq, old;
        logic take, err, found, ahead, behind;
        take = av && ($countones(m_pend) < MAXP);
        err  = take && (int'(af) >= NF);
        newreq = creq;
        if (take && !err) newreq[af] = 1'b1;
        old = m_pend;
        m_pend = m_pend | newreq;
        m_sv = 1'b0;
        if (m_mode == 0) begin
            if (old[m_floor] || newreq[m_floor]) begin
                model_open();
            end else if (old != '0) begin
                found = 1'b0;
                for (int d = 1; d < NF; d++) begin
                    if (!found && m_floor + d < NF && old[m_floor + d]) begin m_dir = 1; found = 1'b1; end
                    if (!found && m_floor - d >= 0 && old[m_floor - d]) begin m_dir = -1; found = 1'b1; end
                end
                m_mode = 1; m_left = TRV;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_floor += m_dir; m_left = TRV;
                if (m_pend[m_floor]) model_open();
            end
        end else begin
            if (newreq[m_floor] || obs) begin
                m_pend[m_floor] = 1'b0; m_left = DR;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_door = 1'b0;
                    ahead = 1'b0; behind = 1'b0;
                    for (int i = 0; i < NF; i++) begin
                        if (m_pend[i] && (i - m_floor) * m_dir > 0) ahead = 1'b1;
                        if (m_pend[i] && (i - m_floor) * m_dir < 0) behind = 1'b1;
                    end
                    if (m_dir != 0 && ahead) begin m_mode = 1; m_left = TRV; end
                    else if (m_dir != 0 && behind) begin m_mode = 1; m_left = TRV; m_dir = -m_dir; end
                    else begin m_mode = 0; m_dir = 0; end
                end
            end
        end
        m_err = err;
    endtask

    function automatic logic [1:0] dir_bits(input int d);
        return (d > 0) ? 2'b11 : ((d < 0) ? 2'b10 : 2'b00);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(bus.assign_valid, bus.assign_floor, bus.cabin_req, bus.door_obstruct);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cmp_liftstate", 32'(bus.liftstate), 32'({dir_bits(m_dir), 4'(m_floor)}));
                chk("cmp_door_open", 32'(bus.door_open), 32'(m_door));
                chk("cmp_pending", 32'(bus.pending), 32'(m_pend));
                chk("cmp_served_valid", 32'(bus.served_valid), 32'(m_sv));
                if (m_sv) chk("cmp_served_floor", 32'(bus.served_floor), 32'(m_sf));
                chk("cmp_assign_err", 32'(bus.assign_err), 32'(m_err));
                chk("cmp_assign_ready", 32'(bus.assign_ready), 32'($countones(m_pend) < MAXP));
            end
        end
    end

    task automatic step_in(input logic av, input logic [3:0] af, input logic [NF-1:0] creq, input logic obs);
        @(posedge clk);
        #2;
        bus.assign_valid  = av;
        bus.assign_floor  = af;
        bus.cabin_req     = creq;
        bus.door_obstruct = obs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.assign_valid = 1'b0; bus.assign_floor = '0; bus.cabin_req = '0; bus.door_obstruct = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    int served_log[8];
    int n_served, dir_log[8], n_dir, open_cnt, first_open, acc_k, served_before;
    logic [1:0] last_dir;
    logic accepted;

    initial begin
        bus.assign_valid = 1'b0; bus.assign_floor = '0; bus.cabin_req = '0; bus.door_obstruct = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_liftstate", 32'(bus.liftstate), 0);
        chk("rst_door_open", 32'(bus.door_open), 0);
        chk("rst_assign_ready", 32'(bus.assign_ready), 1);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_served_valid", 32'(bus.served_valid), 0);

        // Assign floor 3 from rest at floor 0.
        step_in(1'b1, 4'd3, '0, 1'b0);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 2)  chk("t1_dir_up", 32'(bus.liftstate[5:4]), 3);
            if (k == 6)  chk("t1_floor1", 32'(bus.liftstate[3:0]), 1);
            if (k == 10) chk("t1_floor2", 32'(bus.liftstate[3:0]), 2);
            if (k == 14) begin
                chk("t1_floor3", 32'(bus.liftstate[3:0]), 3);
                chk("t1_served_valid", 32'(bus.served_valid), 1);
                chk("t1_served_floor", 32'(bus.served_floor), 3);
                chk("t1_door_open", 32'(bus.door_open), 1);
            end
            if (k == 19) chk("t1_door_still_open", 32'(bus.door_open), 1);
            if (k == 20) begin
                chk("t1_door_closed", 32'(bus.door_open), 0);
                chk("t1_idle_state", 32'(bus.liftstate), 3);
            end
            step_in(1'b0, '0, '0, 1'b0);
        end

        // Out-of-range assignment at floor 3.
        step_in(1'b1, 4'd12, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) chk("t5_ready", 32'(bus.assign_ready), 1);
            if (k == 1) begin
                chk("t5_err_pulse", 32'(bus.assign_err), 1);
                chk("t5_pending", 32'(bus.pending), 0);
                chk("t5_still_idle", 32'(bus.liftstate), 3);
            end
            if (k == 2) chk("t5_err_clear", 32'(bus.assign_err), 0);
            step_in(1'b0, '0, '0, 1'b0);
        end

        // Move to floor 5, then cabin requests 3 and 7 together.
        step_in(1'b1, 4'd5, '0, 1'b0);
        repeat (20) step_in(1'b0, '0, '0, 1'b0);
        step_in(1'b0, '0, 11'b000_1000_1000, 1'b0);
        n_served = 0; n_dir = 0; last_dir = 2'b00;
        for (int i = 0; i < 8; i++) begin served_log[i] = -1; dir_log[i] = -1; end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.served_valid && n_served < 8) begin served_log[n_served] = int'(bus.served_floor); n_served++; end
            if (bus.liftstate[5:4] != last_dir && n_dir < 8) begin dir_log[n_dir] = int'(bus.liftstate[5:4]); n_dir++; end
            last_dir = bus.liftstate[5:4];
            step_in(1'b0, '0, '0, 1'b0);
        end
        chk("t2_served_count", 32'(n_served), 2);
        chk("t2_first_served", 32'(served_log[0]), 7);
        chk("t2_second_served", 32'(served_log[1]), 3);
        chk("t2_dir_changes", 32'(n_dir), 3);
        chk("t2_dir0", 32'(dir_log[0]), 3);
        chk("t2_dir1", 32'(dir_log[1]), 2);
        chk("t2_dir2", 32'(dir_log[2]), 0);

        // Three pending stops block the dispatcher until floor 2 is served.
        do_reset();
        step_in(1'b0, '0, 11'b000_0101_0100, 1'b0);
        n_served = 0; accepted = 1'b0; acc_k = -1; served_before = -1;
        for (int i = 0; i < 8; i++) served_log[i] = -1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (k == 1) chk("t3_ready_low", 32'(bus.assign_ready), 0);
            if (bus.served_valid && n_served < 8) begin served_log[n_served] = int'(bus.served_floor); n_served++; end
            if (!accepted && bus.assign_valid && bus.assign_ready) begin
                accepted = 1'b1; acc_k = k; served_before = n_served;
            end
            step_in(!accepted, 4'd8, '0, 1'b0);
        end
        chk("t3_accepted", 32'(accepted), 1);
        chk("t3_accept_cycle", 32'(acc_k), 10);
        chk("t3_served_before", 32'(served_before), 1);
        chk("t3_served_count", 32'(n_served), 4);
        chk("t3_order0", 32'(served_log[0]), 2);
        chk("t3_order1", 32'(served_log[1]), 4);
        chk("t3_order2", 32'(served_log[2]), 6);
        chk("t3_order3", 32'(served_log[3]), 8);
        chk("t3_final", 32'(bus.liftstate), 8);

        // Door obstructed for the first 10 dwell cycles at floor 4.
        step_in(1'b1, 4'd4, '0, 1'b0);
        open_cnt = 0; first_open = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (bus.door_open) begin
                open_cnt++;
                if (first_open < 0) first_open = k;
            end
            if (k == 18) chk("t4_served_floor", 32'(bus.served_floor), 4);
            step_in(1'b0, '0, '0, (k + 1 >= 18) && (k + 1 < 28));
        end
        chk("t4_first_open", 32'(first_open), 18);
        chk("t4_open_cycles", 32'(open_cnt), 16);

        // Request at the current floor, then the same button mid-dwell.
        step_in(1'b0, '0, 11'b000_0001_0000, 1'b0);
        open_cnt = 0; n_served = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk("t4_latency_closed", 32'(bus.door_open), 0);
            if (k == 1) chk("t4_latency_open", 32'(bus.door_open), 1);
            if (bus.door_open) open_cnt++;
            if (bus.served_valid) n_served++;
            step_in(1'b0, '0, (k + 1 == 4) ? 11'b000_0001_0000 : 11'b0, 1'b0);
        end
        chk("t4_restart_open_cycles", 32'(open_cnt), 10);
        chk("t4_single_served", 32'(n_served), 1);

        // Reset while travelling between floors 2 and 3.
        do_reset();
        step_in(1'b1, 4'd3, '0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 11) begin
                chk("t6_mid_floor", 32'(bus.liftstate), 'h32);
                chk("t6_mid_pending", 32'(bus.pending), 'h8);
            end
            if (k < 11) step_in(1'b0, '0, '0, 1'b0);
        end
        #1 rst = 1'b1;
        #1;
        chk("t6_async_liftstate", 32'(bus.liftstate), 0);
        chk("t6_async_pending", 32'(bus.pending), 0);
        chk("t6_async_door", 32'(bus.door_open), 0);
        chk("t6_async_served", 32'(bus.served_valid), 0);
        chk("t6_async_err", 32'(bus.assign_err), 0);
        chk("t6_async_ready", 32'(bus.assign_ready), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_after_liftstate", 32'(bus.liftstate), 0);
            chk("t6_after_pending", 32'(bus.pending), 0);
            step_in(1'b0, '0, '0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
